encryption_pipeline: RTL and testbench

- Streaming toy-cipher encryptor. Inverse of the team's decryption pipeline.
- Reads plaintext words from a source single-port RAM (synchronous read, 1-cycle latency) and runs each word through an 8-transform pipeline, one word per cycle.
- Writes ciphertext to a destination RAM at the same address.
- Raises finished once the last word has been written.

---
 rtl/encryption_pipeline_pkg.sv | 64 ++++++
 rtl/encryption_pipeline_cipher_stage.sv | 63 ++++++
 rtl/encryption_pipeline.sv | 140 ++++++++++++++
 tb/tb_encryption_pipeline.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/encryption_pipeline_pkg.sv
// Shared constants, state/transform encodings and width-generic bit helpers
// for the toy-cipher encryption and decryption pipelines.
package encryption_pipeline_pkg;

    localparam int NUM_STAGES   = 8;
    localparam int PIPE_LATENCY = 10;
    localparam int MAX_W        = 64;

    localparam logic [MAX_W-1:0] W_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        XF_XOR,
        XF_NEG,
        XF_ROTR,
        XF_ROTL,
        XF_ADD,
        XF_SUB
    } xform_e;

    function automatic logic [MAX_W-1:0] width_mask(input int w);
        return (w >= MAX_W) ? '1 : ((W_ONE << w) - W_ONE);
    endfunction

    // Helpers operate on the low w bits of a MAX_W container; callers slice.
    function automatic logic [MAX_W-1:0] rot_right(input logic [MAX_W-1:0] x,
                                                   input int w, input int n);
        logic [MAX_W-1:0] xm;
        int               s;
        xm = x & width_mask(w);
        s  = n % w;
        if (s == 0) return xm;
        return ((xm >> s) | (xm << (w - s))) & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] rot_left(input logic [MAX_W-1:0] x,
                                                  input int w, input int n);
        return rot_right(x, w, w - (n % w));
    endfunction

    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x, input int w);
        return (~x + W_ONE) & width_mask(w);
    endfunction

    function automatic xform_e encrypt_xform(input int idx);
        case (idx)
            0:       return XF_XOR;
            1:       return XF_NEG;
            2:       return XF_ROTR;
            3:       return XF_ADD;
            4:       return XF_XOR;
            5:       return XF_NEG;
            6:       return XF_ROTR;
            default: return XF_XOR;
        endcase
    endfunction

endpackage

// File: rtl/encryption_pipeline_cipher_stage.sv
// One registered cipher stage carrying {valid, addr, data}; the transform is
// fixed at elaboration by SEL. addr/data hold while no valid word passes.
module cipher_stage
    import encryption_pipeline_pkg::*;
#(
    parameter int     ADDR_WIDTH = 4,
    parameter int     DATA_WIDTH = 8,
    parameter int     ROT        = DATA_WIDTH/2 - 1,
    parameter xform_e SEL        = XF_XOR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] key,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [MAX_W-1:0]      d64, k64, a64, r64;
    logic [DATA_WIDTH-1:0] xf_data;

    always_comb begin
        d64 = '0;
        k64 = '0;
        a64 = '0;
        d64[DATA_WIDTH-1:0] = in_data;
        k64[DATA_WIDTH-1:0] = key;
        a64[ADDR_WIDTH-1:0] = in_addr;
        case (SEL)
            XF_XOR:  r64 = d64 ^ k64;
            XF_NEG:  r64 = negate(d64, DATA_WIDTH);
            XF_ROTR: r64 = rot_right(d64, DATA_WIDTH, ROT);
            XF_ROTL: r64 = rot_left(d64, DATA_WIDTH, ROT);
            // Address wider than the word is truncated by the final slice.
            XF_ADD:  r64 = d64 + a64;
            XF_SUB:  r64 = d64 - a64;
            default: r64 = d64;
        endcase
    end

    assign xf_data = r64[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_addr <= in_addr;
                out_data <= xf_data;
            end
        end
    end

endmodule

// File: rtl/encryption_pipeline.sv
// Streaming toy-cipher encryptor: reads plaintext from a sync-read RAM, runs
// it through eight registered transforms, writes ciphertext at the same address.
//
// state    | meaning
// ST_IDLE  | waiting for ena with finished low; latches num_words
// ST_RUN   | issuing one source read per cycle, addresses 0..num_words-1
// ST_DRAIN | reads done, waiting for the pipeline to empty
// ST_DONE  | finished=1, held until ena drops
module encryption_pipeline
    import encryption_pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ROT        = DATA_WIDTH/2 - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [DATA_WIDTH-1:0] key,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  finished,
    output logic                  mem_wr_ena,
    output logic [ADDR_WIDTH-1:0] memIn_addr,
    output logic [ADDR_WIDTH-1:0] memOut_addr,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    state_e                state, next_state;
    logic [ADDR_WIDTH:0]   num_reg;
    logic                  rd_issued, rd_d;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic                  f_valid;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic [DATA_WIDTH-1:0] f_data;
    logic                  start, flush, is_last, pipe_empty;

    logic                  stg_valid [0:NUM_STAGES];
    logic [ADDR_WIDTH-1:0] stg_addr  [0:NUM_STAGES];
    logic [DATA_WIDTH-1:0] stg_data  [0:NUM_STAGES];

    assign start   = ena && !finished;
    assign flush   = ((state == ST_RUN) || (state == ST_DRAIN)) && !ena;
    // Compare one bit wider so a full-depth job ends at all-ones without wrapping.
    assign is_last = (({1'b0, memIn_addr} + CNT_ONE) == num_reg);

    always_comb begin
        pipe_empty = !rd_issued && !rd_d;
        for (int i = 0; i <= NUM_STAGES; i++) begin
            if (stg_valid[i]) pipe_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = (num_words == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (!ena) next_state = ST_IDLE;
                      else if (is_last) next_state = ST_DRAIN;
            ST_DRAIN: if (!ena) next_state = ST_IDLE;
                      else if (pipe_empty) next_state = ST_DONE;
            ST_DONE:  if (!ena) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finished   <= 1'b0;
            num_reg    <= '0;
            memIn_addr <= '0;
            rd_issued  <= 1'b0;
            rd_d       <= 1'b0;
            rd_addr_d  <= '0;
            f_valid    <= 1'b0;
            f_addr     <= '0;
            f_data     <= '0;
        end else begin
            finished  <= (next_state == ST_DONE);
            rd_d      <= rd_issued && !flush;
            rd_addr_d <= memIn_addr;
            f_valid   <= rd_d && !flush;
            if (rd_d) begin
                f_addr <= rd_addr_d;
                f_data <= data_in;
            end
            case (state)
                ST_IDLE: begin
                    rd_issued <= 1'b0;
                    if (start) begin
                        num_reg    <= num_words;
                        memIn_addr <= '0;
                        rd_issued  <= (num_words != '0);
                    end
                end
                ST_RUN: begin
                    if (!ena || is_last) rd_issued <= 1'b0;
                    else                 memIn_addr <= memIn_addr + 1'b1;
                end
                default: rd_issued <= 1'b0;
            endcase
        end
    end

    assign stg_valid[0] = f_valid;
    assign stg_addr[0]  = f_addr;
    assign stg_data[0]  = f_data;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        cipher_stage #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ROT        (ROT),
            .SEL        (encrypt_xform(i))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .key       (key),
            .in_valid  (stg_valid[i]),
            .in_addr   (stg_addr[i]),
            .in_data   (stg_data[i]),
            .out_valid (stg_valid[i+1]),
            .out_addr  (stg_addr[i+1]),
            .out_data  (stg_data[i+1])
        );
    end

    assign mem_wr_ena  = stg_valid[NUM_STAGES];
    assign memOut_addr = stg_addr[NUM_STAGES];
    assign data_out    = stg_data[NUM_STAGES];

endmodule

// File: tb/tb_encryption_pipeline.sv
// Directed-plus-random bench for encryption_pipeline with RAM models and an
// arithmetic cipher/decipher reference.
module tb_encryption_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [4:0] num_words;
    logic [7:0] key;
    logic [7:0] data_in;
    logic       finished;
    logic       mem_wr_ena;
    logic [3:0] memIn_addr;
    logic [3:0] memOut_addr;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [7:0] src_ram [0:15];
    int wr_cyc[$];
    int wr_addr[$];
    int wr_data[$];

    encryption_pipeline #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .num_words   (num_words),
        .key         (key),
        .data_in     (data_in),
        .finished    (finished),
        .mem_wr_ena  (mem_wr_ena),
        .memIn_addr  (memIn_addr),
        .memOut_addr (memOut_addr),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_in <= src_ram[memIn_addr];

    always @(negedge clk) begin
        cyc_n++;
        if (mem_wr_ena) begin
            wr_cyc.push_back(cyc_n);
            wr_addr.push_back(int'(memOut_addr));
            wr_data.push_back(int'(data_out));
        end
    end

    function automatic int rotr3(int x); return ((x >> 3) | (x << 5)) & 255; endfunction
    function automatic int rotl3(int x); return ((x << 3) | (x >> 5)) & 255; endfunction
    function automatic int neg8(int x);  return (256 - x) & 255;             endfunction

    function automatic int enc(int d, int a, int k);
        int v;
        v = neg8(d ^ k);
        v = rotr3(v);
        v = ((v + a) & 255) ^ k;
        v = rotr3(neg8(v));
        return v ^ k;
    endfunction

    function automatic int dec(int c, int a, int k);
        int v;
        v = neg8(rotl3(c ^ k)) ^ k;
        v = (v - a) & 255;
        v = neg8(rotl3(v));
        return v ^ k;
    endfunction

    function automatic int wd(int i);
        if (i < wr_data.size()) return wr_data[i];
        return -1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_finished"}, int'(finished), 0);
        check({tag, "_wr_ena"},   int'(mem_wr_ena), 0);
        check({tag, "_in_addr"},  int'(memIn_addr), 0);
        check({tag, "_out_addr"}, int'(memOut_addr), 0);
        check({tag, "_data_out"}, int'(data_out), 0);
    endtask

    // Starts a job, waits (bounded) for finished, then checks every write.
    task automatic run_job(input int n, input int k, output int lat, output bit wrap);
        int t0, prev;
        @(negedge clk); #1;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        num_words = 5'(n);
        key       = 8'(k);
        ena       = 1'b1;
        t0   = cyc_n;
        prev = 0;
        wrap = 1'b0;
        lat  = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (c == 0 && n > 0) check("start_addr", int'(memIn_addr), 0);
            if (int'(memIn_addr) < prev) wrap = 1'b1;
            prev = int'(memIn_addr);
            if (finished) begin
                lat = cyc_n - t0;
                break;
            end
        end
        check("finished", int'(finished), 1);
        check("write_count", wr_data.size(), n);
        for (int i = 0; i < wr_data.size() && i < n; i++) begin
            check("wr_addr", wr_addr[i], i);
            check("wr_cycle", wr_cyc[i], t0 + 11 + i);
            check("wr_data", wr_data[i], enc(int'(src_ram[i]), i, k));
            check("roundtrip", dec(wr_data[i], wr_addr[i], k), int'(src_ram[wr_addr[i]]));
        end
    endtask

    task automatic stop_job();
        ena = 1'b0;
        @(negedge clk); #1;
        check("finished_clear", int'(finished), 0);
    endtask

    initial begin
        int  lat;
        bit  wrap;
        int  k;
        rst = 1'b1; ena = 1'b0; num_words = '0; key = '0;
        for (int i = 0; i < 16; i++) src_ram[i] = 8'(i * 7);

        @(negedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single word, plaintext 0 at address 0 must still be written.
        src_ram[0] = 8'h00;
        run_job(1, 8'h5A, lat, wrap);
        check("one_word_const", wd(0), 8'h14);
        stop_job();

        for (int i = 0; i < 16; i++) src_ram[i] = 8'($urandom_range(0, 255));
        src_ram[3] = 8'h01;
        run_job(4, 8'h5A, lat, wrap);
        check("four_word_const", wd(3), 8'h38);
        // ena held in DONE must not restart the job.
        repeat (5) @(negedge clk);
        #1;
        check("done_hold_finished", int'(finished), 1);
        check("done_hold_writes", wr_data.size(), 4);
        stop_job();

        for (int i = 0; i < 16; i++) src_ram[i] = 8'($urandom_range(0, 255));
        k = int'($urandom_range(0, 255));
        run_job(16, k, lat, wrap);
        check("full_last_addr", int'(memIn_addr), 15);
        check("full_no_wrap", int'(wrap), 0);
        stop_job();

        run_job(0, 8'h33, lat, wrap);
        check("zero_done_fast", int'(lat >= 0 && lat <= 2), 1);
        stop_job();

        // Abort after five RUN cycles.
        @(negedge clk); #1;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        num_words = 5'd16; key = 8'hC3; ena = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("abort_in_run_addr", int'(memIn_addr), 4);
        ena = 1'b0;
        @(negedge clk); #1;
        check("abort_wr_ena", int'(mem_wr_ena), 0);
        check("abort_finished", int'(finished), 0);
        repeat (15) @(negedge clk);
        #1;
        check("abort_no_writes", wr_data.size(), 0);
        check("abort_finished_low", int'(finished), 0);
        k = int'($urandom_range(0, 255));
        run_job(3, k, lat, wrap);
        stop_job();

        // Asynchronous reset during DRAIN.
        @(negedge clk); #1;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        num_words = 5'd4; key = 8'h77; ena = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("drain_addr", int'(memIn_addr), 3);
        rst = 1'b1;
        #1;
        check_reset_outputs("midjob_reset");
        ena = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("post_reset_no_writes", wr_data.size(), 0);
        check("post_reset_finished", int'(finished), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
